approx_divider_seq: RTL



---
 rtl/approx_arith_pkg.sv | 28 ++
 rtl/approx_divider_seq_lod.sv | 23 ++
 rtl/approx_divider_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/approx_arith_pkg.sv
// Shared constants, FSM state encoding and width helpers for the approximate divider.
package approx_arith_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_NUM   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_DIV,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Iteration counter must hold 0..2*NUM-1.
    function automatic int cnt_width(input int num);
        return $clog2(2 * num);
    endfunction

    // Signed exponent difference spans roughly -WIDTH..+WIDTH, plus a sign bit.
    function automatic int shift_width(input int width);
        return $clog2(width) + 2;
    endfunction

    localparam int DEF_CNT_W   = cnt_width(DEF_NUM);
    localparam int DEF_SHIFT_W = shift_width(DEF_WIDTH);

endpackage

// File: rtl/approx_divider_seq_lod.sv
// Priority encoder: position of the most significant set bit, plus an all-zero flag.
module leading_one_detector #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         val_i,
    output logic [$clog2(WIDTH)-1:0] pos_o,
    output logic                     zero_o
);

    localparam int POS_W = $clog2(WIDTH);

    always_comb begin
        pos_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (val_i[i]) begin
                pos_o = POS_W'(i);
            end
        end
    end

    assign zero_o = (val_i == '0);

endmodule

// File: rtl/approx_divider_seq.sv
// Sequential leading-one-truncation approximate divider, one quotient bit per clock.
// APPROX_DIV_ROUND_EN: round half-up on the final right shift instead of truncating.
module approx_divider_seq
    import approx_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM   = DEF_NUM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             div_by_zero
);

    localparam int QW    = 2 * NUM;
    localparam int POS_W = $clog2(WIDTH);
    localparam int CW    = cnt_width(NUM);
    localparam int SHW   = shift_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [NUM-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [POS_W-1:0]   ea_q, ea_d, eb_q, eb_d;
    logic [QW-1:0]      n_q, n_d, q_q, q_d;
    logic [NUM-1:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               dbz_q, dbz_d;

    logic [POS_W-1:0]   pos_a, pos_b;
    logic               zero_a, zero_b;
    logic [NUM-1:0]     ma_n, mb_n;
    logic [POS_W-1:0]   ea_n, eb_n;
    logic [NUM:0]       rem_sh, rem_diff;
    logic               qbit;
    logic signed [SHW-1:0] s_val;
    logic [SHW-1:0]     rs;
    logic [QW:0]        half, q_rnd;
    logic [WIDTH-1:0]   y_sh;

    leading_one_detector #(.WIDTH(WIDTH)) u_lod_a (
        .val_i (a_q),
        .pos_o (pos_a),
        .zero_o(zero_a)
    );

    leading_one_detector #(.WIDTH(WIDTH)) u_lod_b (
        .val_i (b_q),
        .pos_o (pos_b),
        .zero_o(zero_b)
    );

    // Mantissa starts at the leading one; small operands keep their low NUM bits unshifted.
    always_comb begin
        ea_n = '0;
        ma_n = a_q[NUM-1:0];
        if (int'(pos_a) >= NUM) begin
            ea_n = POS_W'(int'(pos_a) - NUM + 1);
            ma_n = NUM'(a_q >> ea_n);
        end
        eb_n = '0;
        mb_n = b_q[NUM-1:0];
        if (int'(pos_b) >= NUM) begin
            eb_n = POS_W'(int'(pos_b) - NUM + 1);
            mb_n = NUM'(b_q >> eb_n);
        end
    end

    // Partial remainder stays below mb, so NUM bits suffice between iterations.
    always_comb begin
        rem_sh   = {rem_q, n_q[QW-1]};
        rem_diff = rem_sh - {1'b0, mb_q};
        qbit     = (rem_sh >= {1'b0, mb_q});
    end

    always_comb begin
        s_val = signed'(SHW'(ea_q)) - signed'(SHW'(eb_q)) - signed'(SHW'(NUM));
        rs    = SHW'(-s_val);
        half  = '0;
        q_rnd = '0;
        y_sh  = '0;
        if (!s_val[SHW-1]) begin
            y_sh = WIDTH'(q_q) << s_val;
        end else if (rs <= SHW'(QW)) begin
`ifdef APPROX_DIV_ROUND_EN
            half  = (QW+1)'(1) << (rs - SHW'(1));
            q_rnd = {1'b0, q_q} + half;
            y_sh  = WIDTH'(q_rnd >> rs);
`else
            y_sh  = WIDTH'(q_q >> rs);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        n_d     = n_q;
        q_d     = q_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (zero_b) begin
                    y_d     = '1;
                    dbz_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (zero_a) begin
                    y_d     = '0;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    ma_d    = ma_n;
                    mb_d    = mb_n;
                    ea_d    = ea_n;
                    eb_d    = eb_n;
                    n_d     = {ma_n, {NUM{1'b0}}};
                    q_d     = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d = qbit ? rem_diff[NUM-1:0] : rem_sh[NUM-1:0];
                q_d   = {q_q[QW-2:0], qbit};
                n_d   = n_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                y_d     = y_sh;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            ma_q  <= '0;
            mb_q  <= '0;
            ea_q  <= '0;
            eb_q  <= '0;
            n_q   <= '0;
            q_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            ma_q  <= ma_d;
            mb_q  <= mb_d;
            ea_q  <= ea_d;
            eb_q  <= eb_d;
            n_q   <= n_d;
            q_q   <= q_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
            dbz_q <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign y           = y_q;
    assign div_by_zero = dbz_q;

endmodule
